// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between fetch (IF) and data (MEM) requesters.
// Optional stall counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m,
  output logic [15:0]       perf_fstall,
  output logic [15:0]       perf_mstall,
  output logic [1:0]        dbg_state,
  output logic [3:0]        dbg_streak
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_ACK = 2'd2} state_t;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Handshake: a requester holds req and its operands until its ready pulse;
  // ready is only given while req is still high, and rdata is zero otherwise.
  state_t     state_q, state_d;
  logic       owner_q, owner_d;  // 1 = data port owns the in-flight access
  logic [2:0] lat_cnt_q, lat_cnt_d;
  logic [3:0] streak_q, streak_d;
  logic       drop_q, drop_d;

  logic issue, fetch_forced, grant_d, grant_f, complete;

  always_comb begin
    issue        = (state_q == IDLE) && !reset;
    fetch_forced = if_req && (streak_q == STARVE_LIM);
    grant_d      = issue && dm_req && !fetch_forced;
    grant_f      = issue && if_req && !grant_d;
    complete     = (state_q == RD_WAIT) && (lat_cnt_q == 3'd0);
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    streak_d  = streak_q;
    drop_d    = drop_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (grant_d) begin
          owner_d   = 1'b1;
          lat_cnt_d = LAT_INIT;
          state_d   = dm_we ? WR_ACK : RD_WAIT;
          if (!if_req)                     streak_d = 4'd0;
          else if (streak_q != STARVE_LIM) streak_d = streak_q + 4'd1;
        end else begin
          streak_d = 4'd0;
          if (grant_f) begin
            owner_d   = 1'b0;
            lat_cnt_d = LAT_INIT;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (!owner_q && if_flush) drop_d = 1'b1;
        if (lat_cnt_q == 3'd0) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      WR_ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      lat_cnt_q <= 3'd0;
      streak_q  <= 4'd0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
      streak_q  <= streak_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    mem_en    = grant_d || grant_f;
    mem_we    = grant_d && dm_we;
    mem_addr  = grant_d ? dm_addr : (grant_f ? if_addr : '0);
    mem_wdata = grant_d ? dm_wdata : '0;
    // A flush in the completion cycle itself must also swallow the fetch.
    if_ready  = complete && !owner_q && if_req && !drop_q && !if_flush;
    dm_ready  = ((complete && owner_q) || (state_q == WR_ACK)) && dm_req;
    if_rdata  = if_ready ? mem_rdata : '0;
    dm_rdata  = (dm_ready && state_q == RD_WAIT) ? mem_rdata : '0;
    stall_f   = if_req && !if_ready;
    stall_m   = dm_req && !dm_ready;
    dbg_state  = state_q;
    dbg_streak = streak_q;
  end

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_fstall_q, perf_fstall_d;
  logic [15:0] perf_mstall_q, perf_mstall_d;

  always_comb begin
    perf_fstall_d = perf_fstall_q;
    perf_mstall_d = perf_mstall_q;
    if (stall_f && perf_fstall_q != 16'hFFFF) perf_fstall_d = perf_fstall_q + 16'd1;
    if (stall_m && perf_mstall_q != 16'hFFFF) perf_mstall_d = perf_mstall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fstall_q <= 16'd0;
      perf_mstall_q <= 16'd0;
    end else begin
      perf_fstall_q <= perf_fstall_d;
      perf_mstall_q <= perf_mstall_d;
    end
  end

  assign perf_fstall = perf_fstall_q;
  assign perf_mstall = perf_mstall_q;
`else
  assign perf_fstall = 16'd0;
  assign perf_mstall = 16'd0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the pipeline's fetch stage (IF) and memory stage (MEM).
- Grants one access at a time, sequences the fixed read latency and returns ready pulses with read data.
- Generates stall_f/stall_m for the hazard logic.
- Sits between the IF/MEM stage registers and the memory macro; the data port has priority, with a starvation guard for fetch.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from accepted read (mem_en) to valid mem_rdata; legal range 1..7
- STARVE_MAX, 4, consecutive data grants while a fetch is pending before fetch is forced; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  branch/jump redirect; kills an in-flight fetch
- if_ready  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  instruction word
- dm_req  in  1  data request (lw/sw); held with dm_we/addr/wdata until dm_ready
- dm_we  in  1  1 = store
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_ready  out  1  one-cycle pulse; load data valid / store done
- dm_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- stall_f  out  1  if_req & ~if_ready
- stall_m  out  1  dm_req & ~dm_ready
- perf_fstall  out  16  fetch stall cycle count (optional feature)
- perf_mstall  out  16  data stall cycle count (optional feature)

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE; owner=0; lat_cnt=0; streak=0; drop=0.
  - All outputs 0, except stall_f/stall_m, which follow their equations combinationally.
- States:
  - IDLE: issue cycle. Grant decision is combinational. On a grant, mem_en=1 and mem_addr/mem_we/mem_wdata come from the winner.
  - RD_WAIT: lat_cnt counts down from MEM_LAT-1. At lat_cnt==0, ready pulses for owner, rdata=mem_rdata (passthrough), then -> IDLE.
  - WR_ACK: dm_ready=1 for one cycle, then -> IDLE.
- Grant in IDLE:
  - dm_req wins, unless if_req=1 and streak==STARVE_MAX; then fetch wins.
  - A fetch grant or no grant clears streak.
  - A data grant while if_req=1 increments streak, saturating at STARVE_MAX.
  - A data grant while if_req=0 clears streak.
- Transitions out of IDLE:
  - Read grant (fetch, or data with dm_we=0) -> RD_WAIT with lat_cnt=MEM_LAT-1.
  - Store grant -> WR_ACK.
- Latency (issue cycle T):
  - Read: ready asserted in cycle T+MEM_LAT.
  - Store: dm_ready in T+1.
  - Next grant no earlier than the cycle after ready.
  - Back-to-back reads: one access every MEM_LAT+1 cycles.
- Outputs outside the issue cycle: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
- Ready pulses: if_ready/dm_ready are never high together; rdata outputs are 0 when their ready is low.
- Flush:
  - if_flush=1 while owner=fetch in RD_WAIT (including the completion cycle) sets drop. The completion then produces no if_ready and returns to IDLE.
  - if_flush in IDLE has no effect on arbitration; the new if_addr is taken.
  - if_flush never affects a data access.
- Requester drops req before ready (protocol violation): the access still completes internally; the ready pulse is suppressed.
- Reset mid-access: immediate return to IDLE. No ready pulse; the in-flight response is discarded; streak clears.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: perf_fstall/perf_mstall increment each cycle stall_f/stall_m is 1. They saturate at 16'hFFFF and clear on reset.
- Undefined: both ports tied to 0 and no counter registers are built.

Test Plan:
- MEM_LAT=2; fetch-only, if_req=1, if_addr=0x10 at T -> mem_en=1, mem_addr=0x10 at T; if_ready=1 with if_rdata=mem_rdata at T+2; next issue at T+3.
- if_req and dm_req (lw, addr 0x200) both rise at T -> data granted at T, dm_ready at T+2; fetch issued at T+3, if_ready at T+5; stall_f high T..T+4.
- sw addr 0x40, wdata 0xDEADBEEF at T -> mem_en=mem_we=1, mem_wdata=0xDEADBEEF at T; dm_ready at T+1; no mem_en at T+1.
- STARVE_MAX=4, dm_req held with 5 loads, if_req held -> grants D,D,D,D,F,D; streak=0 after the fetch grant.
- Fetch issued at T, if_flush=1 at T+1 -> no if_ready at T+2; state IDLE at T+3; the new if_addr is issued at T+3.
- reset asserted mid-RD_WAIT (T+1) -> outputs 0 immediately, no ready pulse after release. With MEM_ARB_PERF_EN, a 3-cycle fetch stall yields perf_fstall=3.
